// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM states and port identifiers.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_be_merge.sv
// Per-byte merge of new store data over an old word under byte enables.
module be_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   old_i,
  input  logic [WIDTH-1:0]   new_i,
  input  logic [WIDTH/8-1:0] be_i,
  output logic [WIDTH-1:0]   merged_o
);

  localparam int NBE = WIDTH / 8;

  for (genvar b = 0; b < NBE; b++) begin : g_byte
    assign merged_o[8*b +: 8] = be_i[b] ? new_i[8*b +: 8] : old_i[8*b +: 8];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch and the LSU;
// sub-word stores run as a two-cycle read-modify-write.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int NBE    = WIDTH / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [WIDTH-1:0]  if_rdata,
  input  logic              ls_valid,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [WIDTH-1:0]  ls_wdata,
  input  logic [NBE-1:0]    ls_be,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [WIDTH-1:0]  ls_rdata,
  output logic              ram_write_ena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  input  logic [WIDTH-1:0]  ram_rdata
);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [WIDTH-1:0]    merged_q, merged_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [WIDTH-1:0]    if_rdata_q, if_rdata_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic [WIDTH-1:0]    ls_rdata_q, ls_rdata_d;
  logic [WIDTH-1:0]    merged_w;
  logic                grant_ls;
  logic                we_raw;

  be_merge #(.WIDTH(WIDTH)) u_be_merge (
    .old_i    (ram_rdata),
    .new_i    (ls_wdata),
    .be_i     (ls_be),
    .merged_o (merged_w)
  );

  // LSU wins when alone, or on a tie when fetch was granted last.
  assign grant_ls = ls_valid && (!if_valid || (last_grant_q == PORT_IF));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    merged_d     = merged_q;
    addr_d       = addr_q;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rvalid_d  = 1'b0;
    ls_rdata_d   = ls_rdata_q;
    if_ready     = 1'b0;
    ls_ready     = 1'b0;
    we_raw       = 1'b0;
    ram_addr     = if_addr;
    ram_wdata    = ls_wdata;

    case (state_q)
      ST_IDLE: begin
        if (!reset) begin
          if (grant_ls) begin
            last_grant_d = PORT_LS;
            ram_addr     = ls_addr;
            if (!ls_we) begin
              ls_ready    = 1'b1;
              ls_rvalid_d = 1'b1;
              ls_rdata_d  = ram_rdata;
            end else if (ls_be == {NBE{1'b1}}) begin
              ls_ready = 1'b1;
              we_raw   = 1'b1;
            end else if (ls_be == '0) begin
              ls_ready = 1'b1;
            end else begin
              merged_d = merged_w;
              addr_d   = ls_addr;
              state_d  = ST_RMW_WR;
            end
          end else if (if_valid) begin
            last_grant_d = PORT_IF;
            if_ready     = 1'b1;
            if_rvalid_d  = 1'b1;
            if_rdata_d   = ram_rdata;
          end
        end
      end
      ST_RMW_WR: begin
        ram_addr  = addr_q;
        ram_wdata = merged_q;
        we_raw    = 1'b1;
        ls_ready  = !reset;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gate the write combinationally so a reset in the write cycle drops the store.
  assign ram_write_ena = we_raw && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_LS;
      merged_q     <= '0;
      addr_q       <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      ls_rvalid_q  <= 1'b0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      merged_q     <= merged_d;
      addr_q       <= addr_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      ls_rvalid_q  <= ls_rvalid_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int NBE   = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             if_valid, if_ready, if_rvalid;
  logic [AW-1:0]    if_addr;
  logic [WIDTH-1:0] if_rdata;
  logic             ls_valid, ls_we, ls_ready, ls_rvalid;
  logic [AW-1:0]    ls_addr;
  logic [WIDTH-1:0] ls_wdata, ls_rdata;
  logic [NBE-1:0]   ls_be;
  logic             ram_write_ena;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata, ram_rdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ram_write_ena(ram_write_ena), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // RAM: combinational read, write committed on the negedge.
  logic [WIDTH-1:0] ram_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
  always @(negedge clock) if (ram_write_ena) ram_mem[ram_addr] = ram_wdata;
  assign ram_rdata = ram_mem[ram_addr];

  int n_chk  = 0;
  int n_fail = 0;

  // Model: memory image, pending RMW, last grant (1 = LSU), and the registered response values.
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_busy = 1'b0;
  logic [AW-1:0]    m_baddr;
  logic [WIDTH-1:0] m_bdata;
  logic [NBE-1:0]   m_bbe;
  logic             m_last = 1'b1;
  logic             m_if_rv = 1'b0, m_ls_rv = 1'b0;
  logic [WIDTH-1:0] m_if_rd = '0, m_ls_rd = '0;
  logic             m_acc_if, m_acc_ls;
  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

  logic             s_ir, s_lr, s_we, s_irv, s_lrv;
  logic [WIDTH-1:0] s_ird, s_lrd, s_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [AW-1:0] ia,
                      input logic lv, input logic lwe, input logic [AW-1:0] la,
                      input logic [WIDTH-1:0] wd, input logic [NBE-1:0] be);
    logic             e_ir, e_lr, e_we, n_irv, n_lrv, gls;
    logic [AW-1:0]    e_wa;
    logic [WIDTH-1:0] e_wd, n_ird, n_lrd;
    reset = r; if_valid = iv; if_addr = ia;
    ls_valid = lv; ls_we = lwe; ls_addr = la; ls_wdata = wd; ls_be = be;
    @(negedge clock); #1;
    s_ir = if_ready; s_lr = ls_ready; s_we = ram_write_ena; s_wd = ram_wdata;
    s_irv = if_rvalid; s_lrv = ls_rvalid; s_ird = if_rdata; s_lrd = ls_rdata;
    e_ir = 0; e_lr = 0; e_we = 0; e_wa = '0; e_wd = '0;
    n_irv = 0; n_lrv = 0; n_ird = m_if_rd; n_lrd = m_ls_rd;
    if (r) begin
      n_ird = '0; n_lrd = '0; m_busy = 0; m_last = 1;
    end else if (m_busy) begin
      e_we = 1; e_lr = 1; e_wa = m_baddr; e_wd = m_mem[m_baddr];
      for (int b = 0; b < NBE; b++) if (m_bbe[b]) e_wd[8*b +: 8] = m_bdata[8*b +: 8];
      m_mem[m_baddr] = e_wd;
      m_busy = 0;
    end else begin
      gls = lv && (!iv || !m_last);
      if (gls) begin
        m_last = 1;
        if (!lwe) begin
          e_lr = 1; n_lrv = 1; n_lrd = m_mem[la];
        end else if (be == 4'hF) begin
          e_lr = 1; e_we = 1; e_wa = la; e_wd = wd; m_mem[la] = wd;
        end else if (be == 4'h0) begin
          e_lr = 1;
        end else begin
          m_busy = 1; m_baddr = la; m_bdata = wd; m_bbe = be;
        end
      end else if (iv) begin
        m_last = 0; e_ir = 1; n_irv = 1; n_ird = m_mem[ia];
      end
    end
    chk("if_ready", 32'(if_ready), 32'(e_ir));
    chk("ls_ready", 32'(ls_ready), 32'(e_lr));
    chk("ram_write_ena", 32'(ram_write_ena), 32'(e_we));
    chk("if_rvalid", 32'(if_rvalid), 32'(m_if_rv));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(m_ls_rv));
    chk("if_rdata", if_rdata, m_if_rd);
    chk("ls_rdata", ls_rdata, m_ls_rd);
    if (e_we) begin
      chk("ram_addr", 32'(ram_addr), 32'(e_wa));
      chk("ram_wdata", ram_wdata, e_wd);
    end
    m_if_rv = n_irv; m_ls_rv = n_lrv; m_if_rd = n_ird; m_ls_rd = n_lrd;
    m_acc_if = e_ir; m_acc_ls = e_lr;
    @(posedge clock); #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, '0, '0, '0);
  endtask

  logic             riv, rlv, rwe, rr;
  logic [AW-1:0]    ria, rla;
  logic [WIDTH-1:0] rwd;
  logic [NBE-1:0]   rbe;

  initial begin
    reset = 1; if_valid = 0; if_addr = '0; ls_valid = 1; ls_we = 1;
    ls_addr = '0; ls_wdata = '0; ls_be = 4'hF;
    @(posedge clock); #1;

    // Reset with a pending store
    step(1, 0, '0, 1, 1, 10'd3, 32'hFFFF_FFFF, 4'hF);
    chk("rst_we", 32'(s_we), 32'd0);
    chk("rst_ls_ready", 32'(s_lr), 32'd0);
    idle();
    chk("rst_if_rdata", s_ird, 32'd0);
    chk("rst_ls_rdata", s_lrd, 32'd0);

    // Contention: fetch wins the first tie, then alternate
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 10'h10, 1, 0, 10'h20, '0, '0);
      chk("rr_if_ready", 32'(s_ir), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ls_ready", 32'(s_lr), (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    idle();
    chk("rr_ls_rvalid", 32'(s_lrv), 32'd1);

    // Full store then load
    step(0, 0, '0, 1, 1, 10'd5, 32'hDEAD_BEEF, 4'hF);
    chk("fs_ls_ready", 32'(s_lr), 32'd1);
    step(0, 0, '0, 1, 0, 10'd5, '0, '0);
    idle();
    chk("fs_ls_rdata", s_lrd, 32'hDEAD_BEEF);

    // RMW with fetch blocked during the write cycle
    step(0, 0, '0, 1, 1, 10'd7, 32'h1122_3344, 4'hF);
    step(0, 0, '0, 1, 1, 10'd7, 32'hAABB_CCDD, 4'b0101);
    chk("rmw_ready_c1", 32'(s_lr), 32'd0);
    step(0, 1, 10'd2, 1, 1, 10'd7, 32'hAABB_CCDD, 4'b0101);
    chk("rmw_ready_c2", 32'(s_lr), 32'd1);
    chk("rmw_if_ready", 32'(s_ir), 32'd0);
    chk("rmw_wdata", s_wd, 32'h11BB_33DD);
    step(0, 1, 10'd2, 0, 0, '0, '0, '0);
    step(0, 0, '0, 1, 0, 10'd7, '0, '0);
    idle();
    chk("rmw_load", s_lrd, 32'h11BB_33DD);

    // Empty byte enable store
    step(0, 0, '0, 1, 1, 10'd7, 32'hFFFF_FFFF, 4'h0);
    chk("be0_ready", 32'(s_lr), 32'd1);
    chk("be0_we", 32'(s_we), 32'd0);
    step(0, 0, '0, 1, 0, 10'd7, '0, '0);
    idle();
    chk("be0_load", s_lrd, 32'h11BB_33DD);

    // Reset in the RMW write cycle
    step(0, 0, '0, 1, 1, 10'd7, 32'h5555_5555, 4'b0011);
    step(1, 0, '0, 1, 1, 10'd7, 32'h5555_5555, 4'b0011);
    chk("rstrmw_we", 32'(s_we), 32'd0);
    step(0, 1, 10'h10, 1, 0, 10'd7, '0, '0);
    chk("rstrmw_if_wins", 32'(s_ir), 32'd1);
    step(0, 0, '0, 1, 0, 10'd7, '0, '0);
    idle();
    chk("rstrmw_load", s_lrd, 32'h11BB_33DD);

    // Random traffic, requests held until accepted
    riv = 0; rlv = 0; ria = '0; rla = '0; rwe = 0; rwd = '0; rbe = '0;
    for (int c = 0; c < 3000; c++) begin
      rr = ($urandom_range(0, 99) == 0);
      if (!riv && $urandom_range(0, 2) != 0) begin
        riv = 1; ria = AW'($urandom_range(0, 63));
      end
      if (!rlv && $urandom_range(0, 2) != 0) begin
        rlv = 1; rla = AW'($urandom_range(0, 63)); rwe = 1'($urandom_range(0, 1));
        rwd = $urandom;
        case ($urandom_range(0, 3))
          0: rbe = 4'hF;
          1: rbe = 4'h0;
          default: rbe = 4'($urandom_range(0, 15));
        endcase
      end
      step(rr, riv, ria, rlv, rwe, rla, rwd, rbe);
      if (m_acc_if) riv = 0;
      if (m_acc_ls) rlv = 0;
    end
    idle();
    idle();

    for (int a = 0; a < 64; a++) chk("mem_image", ram_mem[a], m_mem[a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
